parity_push_stage: RTL and testbench
====================================

# parity_push_stage

Upstream feeder for the parity-checked FIFO (`top`). It accepts raw `DATA_WIDTH`-bit words from a source over a valid/ready handshake and computes a parity bit per word. It inserts that bit at the configured position and drives the resulting `DATA_WIDTH+1`-bit word into the FIFO push port through a 2-entry skid buffer, sustaining one word per cycle. A pending-error injector lets benches force a bad-parity word so the FIFO's pop-side parity drop can be exercised.

## Interface
- `DATA_WIDTH`, 32: payload width; the output word is `DATA_WIDTH+1` bits.
- `EVEN_ODD`, 0: parity sense.
  - 0: even (total ones in the output word, parity bit included, is even).
  - 1: odd.
- `PARITY_BIT`, 0: parity bit position.
  - 0: parity at bit 0, payload at `[DATA_WIDTH:1]`.
  - 1: parity at bit `DATA_WIDTH`, payload at `[DATA_WIDTH-1:0]`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `src_data_i` in `DATA_WIDTH`: raw payload.
- `src_valid_i` in 1: source has a word.
- `src_ready_o` out 1: stage can accept; a transfer occurs on a rising edge with `src_valid_i & src_ready_o`.
- `inj_err_i` in 1: request parity inversion on the next accepted word.
- `push_data_o` out `DATA_WIDTH+1`: word to the FIFO `push_data_i`.
- `push_valid_o` out 1: to the FIFO `push_valid_i`.
- `push_grant_i` in 1: from the FIFO `push_grant_o`; a transfer occurs on a rising edge with `push_valid_o & push_grant_i`.
- `inj_pending_o` out 1: an injection is armed and not yet consumed.
- `word_cnt_o` out 16: count of words delivered downstream.

## Operation
- Parity is the XOR-reduce of `src_data_i`, inverted when `EVEN_ODD=1`. When a corruption is applied, the computed bit is additionally inverted. The payload is never modified.
- The buffer holds two registers: `main` drives `push_data_o`; `skid` catches the overflow.
- FSM states:
  - EMPTY: `push_valid_o=0`, ready.
  - BUSY: `main` valid, ready.
  - FULL: `main` and `skid` valid, not ready.
- FSM transitions (acc = source transfer, gnt = downstream transfer):
  - EMPTY: acc → BUSY (`main` loaded); otherwise stay.
  - BUSY:
    - acc & !gnt → FULL (`skid` loaded).
    - !acc & gnt → EMPTY.
    - acc & gnt → BUSY (`main` reloaded).
    - neither → stay, `main` held.
  - FULL: gnt → BUSY (`main` ← `skid`); otherwise stay. acc is impossible.
- `src_ready_o = (state != FULL) & live`. `live` is a flop reset to 0 that sets on the first rising edge after `rst` falls.
- `push_data_o` is held stable while `push_valid_o=1` and gnt is low.
- Injection:
  - `inj_err_i` high at an edge sets `pending`.
  - The first acc at or after that edge is corrupted and clears `pending`.
  - If `inj_err_i` and acc occur on the same edge, that word is corrupted and `pending` ends at 0.
  - Further `inj_err_i` pulses while `pending=1` are absorbed (no stacking).
- `word_cnt_o` increments by 1 per gnt and wraps from 0xFFFF to 0x0000.

## Timing
- Latency: a word accepted at edge N appears on `push_data_o`/`push_valid_o` after edge N; it is deliverable at edge N+1.
- Throughput: 1 word/cycle when `push_grant_i` is held high.
- `src_ready_o` is registered (decoded from state flops, no combinational path from `push_grant_i`).
- After the FIFO grant drops, the stage absorbs at most 1 more word, then `src_ready_o=0`.
- Reset values, applied asynchronously on `rst` rise:
  - `push_valid_o=0`, `push_data_o=0`, `src_ready_o=0`.
  - `inj_pending_o=0`, `word_cnt_o=0`.
  - State = EMPTY.
- Reset mid-operation discards `main`, `skid` and `pending`. No partial word reaches the FIFO after `rst` rises.
- `src_ready_o` first returns to 1 one edge after `rst` deassertion.
- Behaviour with `push_grant_i=1` while `push_valid_o=0` is don't-care: no state change, no count.

## Test plan
- Reset: assert `rst` for 2.5 ns mid-cycle with both registers full. Required: all outputs 0 immediately; `src_ready_o` returns to 1 one edge after release; `word_cnt_o=0`.
- Parity encoding, `PARITY_BIT=0`, `EVEN_ODD=0`, grant high:
  - send 0x00000003 → `push_data_o=33'h000000006`;
  - send 0x00000001 → `33'h000000003`.
- Parity encoding, `PARITY_BIT=1`, `EVEN_ODD=1`: send 0x00000003 → `33'h100000003`.
- Backpressure, grant low, stream 0x11, 0x22, 0x33:
  - Required: `src_ready_o=0` after 2 acceptances, so 0x33 is stalled.
  - Raise grant: FIFO receives 0x11, 0x22, 0x33 in order on consecutive edges; `word_cnt_o=3`.
- Injection, default parameters:
  - pulse `inj_err_i` twice, then send 0x00000001, 0x00000001;
  - Required: first word `33'h000000002`, second word `33'h000000003`, `inj_pending_o` 1 → 0 on the first accept.
  - Connected to the FIFO (same parity parameters), only the second word pops.
- Wrap: deliver 65537 words with grant high → `word_cnt_o=1`; no bubbles, with `push_valid_o` high every cycle after the first.

Source files
------------

// File: rtl/parity_push_stage.sv
// Parity-encoding feeder for the parity-checked FIFO: valid/ready intake,
// parity insertion with error injection, 2-entry skid buffer to the push port.
module parity_push_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EVEN_ODD   = 0,
  parameter int unsigned PARITY_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic                  inj_err_i,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic                  inj_pending_o,
  output logic [15:0]           word_cnt_o
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  localparam logic SENSE = (EVEN_ODD != 0);

  state_t              state_q, state_d;
  logic                live_q;
  logic                pending_q;
  logic [DATA_WIDTH:0] main_q, skid_q;
  logic [15:0]         cnt_q;

  logic                acc, gnt, corrupt, par_bit;
  logic [DATA_WIDTH:0] enc_word;

  assign acc     = src_valid_i & src_ready_o;
  assign gnt     = push_valid_o & push_grant_i;
  assign corrupt = acc & (pending_q | inj_err_i);
  assign par_bit = (^src_data_i) ^ SENSE ^ corrupt;

  always_comb begin
    enc_word = '0;
    if (PARITY_BIT != 0) enc_word = {par_bit, src_data_i};
    else                 enc_word = {src_data_i, par_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (acc) state_d = BUSY;
      BUSY: begin
        if (acc && !gnt)      state_d = FULL;
        else if (!acc && gnt) state_d = EMPTY;
      end
      FULL:    if (gnt) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
  end

  // Ready is decoded from flops only, so the grant never reaches src_ready_o.
  always_comb begin
    push_valid_o = (state_q != EMPTY);
    src_ready_o  = (state_q != FULL) & live_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (acc) main_q <= enc_word;
        BUSY: begin
          if (acc && gnt) main_q <= enc_word;
          else if (acc)   skid_q <= enc_word;
        end
        FULL:    if (gnt) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  // Same-edge request and accept consumes the request without arming it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q    <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      live_q <= 1'b1;
      if (acc)            pending_q <= 1'b0;
      else if (inj_err_i) pending_q <= 1'b1;
      if (gnt) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign push_data_o   = main_q;
  assign inj_pending_o = pending_q;
  assign word_cnt_o    = cnt_q;

endmodule

// File: tb/tb_parity_push_stage.sv
// Randomized self-checking bench for parity_push_stage using a queue-based
// reference model of accepted-but-undelivered words.
`timescale 1ns/1ps
module tb_parity_push_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_data;
  logic        src_valid, inj, grant;
  logic        ready_a, valid_a, pend_a, ready_b, valid_b, pend_b;
  logic [32:0] data_a, data_b;
  logic [15:0] cnt_a, cnt_b;

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(0)) dut_a (
    .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
    .src_ready_o(ready_a), .inj_err_i(inj), .push_data_o(data_a),
    .push_valid_o(valid_a), .push_grant_i(grant), .inj_pending_o(pend_a),
    .word_cnt_o(cnt_a));

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(1), .PARITY_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
    .src_ready_o(ready_b), .inj_err_i(inj), .push_data_o(data_b),
    .push_valid_o(valid_b), .push_grant_i(grant), .inj_pending_o(pend_b),
    .word_cnt_o(cnt_b));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; bit c;} item_t;
  item_t       q[$];
  bit          m_pending, m_live, last_gnt;
  logic [15:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [32:0] enc(item_t it, bit pb, bit eo);
    bit p;
    p = (($countones(it.d) % 2) == 1) ^ eo ^ it.c;
    return pb ? {p, it.d} : {it.d, p};
  endfunction

  function automatic bit m_ready();
    return m_live && (q.size() < 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pending = 0;
    m_live    = 0;
    m_cnt     = '0;
  endtask

  // Inputs are set just after a falling edge; advance one cycle and the model.
  task automatic step();
    bit acc, gnt, cor;
    item_t it;
    acc = src_valid && m_ready();
    gnt = grant && (q.size() > 0);
    cor = acc && (m_pending || inj);
    it.d = src_data;
    it.c = cor;
    @(posedge clk);
    if (gnt) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (acc) q.push_back(it);
    m_pending = acc ? 1'b0 : (m_pending | inj);
    m_live    = 1;
    last_gnt  = gnt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; src_valid = 0; inj = 0; grant = 0; src_data = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
    checks++; if (data_a !== 33'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_a); end
    checks++; if (cnt_a !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", cnt_a); end
    rst = 0;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", ready_a); end
    step();
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", ready_a); end
    // Fill both registers, arm an injection, then reset mid-cycle.
    grant = 1; src_valid = 1; src_data = $urandom; step();
    src_data = $urandom; step();
    grant = 0; src_data = $urandom; step();
    inj = 1; src_data = $urandom; step();
    inj = 0; src_valid = 0;
    checks++; if ({valid_a, ready_a, pend_a} !== {1'b1, m_ready(), m_pending}) begin
      errors++; $display("FAIL prefill got v%b r%b p%b want v1 r%b p%b", valid_a, ready_a, pend_a, m_ready(), m_pending); end
    checks++; if (cnt_a !== m_cnt) begin errors++; $display("FAIL prefill_cnt got %h want %h", cnt_a, m_cnt); end
    #1 rst = 1;
    #1;
    checks++; if ({valid_a, ready_a, pend_a, cnt_a, data_a} !== '0) begin
      errors++; $display("FAIL async_reset got v%b r%b p%b c%h d%h want all 0", valid_a, ready_a, pend_a, cnt_a, data_a); end
    #1.5 rst = 0;
    model_reset();
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL ready_post_release got %b want 0", ready_a); end
    step();
    checks++; if ({ready_a, valid_a, cnt_a} !== {1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL ready_one_edge got r%b v%b c%h want r1 v0 c0", ready_a, valid_a, cnt_a); end
  endtask

  task automatic test_parity_encoding();
    grant = 1; src_valid = 1; src_data = 32'h3; step();
    checks++; if (data_a !== 33'h000000006) begin errors++; $display("FAIL enc_p0_e0_3 got %h want 000000006", data_a); end
    checks++; if (data_b !== 33'h100000003) begin errors++; $display("FAIL enc_p1_e1_3 got %h want 100000003", data_b); end
    src_data = 32'h1; step();
    checks++; if (data_a !== 33'h000000003) begin errors++; $display("FAIL enc_p0_e0_1 got %h want 000000003", data_a); end
    src_valid = 0; step();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL enc_drain got %b want 0", valid_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [3];
    logic [15:0] cnt0;
    item_t it;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    cnt0 = m_cnt;
    grant = 0; src_valid = 1;
    src_data = words[0]; step();
    src_data = words[1]; step();
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL bp_ready_after_2 got %b want 0", ready_a); end
    src_data = words[2]; step();
    checks++; if ({ready_a, q.size()} !== {1'b0, 32'd2}) begin
      errors++; $display("FAIL bp_stall got r%b want r0 (model depth %0d)", ready_a, q.size()); end
    it.c = 0;
    it.d = words[0];
    checks++; if (data_a !== enc(it, 0, 0)) begin errors++; $display("FAIL bp_hold got %h want %h", data_a, enc(it, 0, 0)); end
    grant = 1;
    for (int i = 0; i < 3; i++) begin
      it.d = words[i];
      checks++; if ({valid_a, data_a} !== {1'b1, enc(it, 0, 0)}) begin
        errors++; $display("FAIL bp_order%0d got v%b %h want v1 %h", i, valid_a, data_a, enc(it, 0, 0)); end
      if (i == 1) src_valid = 1;
      step();
      src_valid = (i == 0);
    end
    src_valid = 0;
    checks++; if (cnt_a - cnt0 !== 16'd3) begin errors++; $display("FAIL bp_count got %0d want 3", cnt_a - cnt0); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", valid_a); end
  endtask

  task automatic test_injection();
    grant = 1; src_valid = 0; src_data = 32'h1;
    inj = 1; step(); inj = 0; step(); inj = 1; step(); inj = 0;
    checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL inj_armed got %b want 1", pend_a); end
    src_valid = 1; step();
    checks++; if (data_a !== 33'h000000002) begin errors++; $display("FAIL inj_first got %h want 000000002", data_a); end
    checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL inj_cleared got %b want 0", pend_a); end
    step();
    checks++; if (data_a !== 33'h000000003) begin errors++; $display("FAIL inj_second got %h want 000000003", data_a); end
    inj = 1; step(); inj = 0;
    checks++; if ({data_a, pend_a} !== {33'h000000002, 1'b0}) begin
      errors++; $display("FAIL inj_same_edge got %h p%b want 000000002 p0", data_a, pend_a); end
    src_valid = 0; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = $urandom;
      grant     = ($urandom_range(0, 3) != 0);
      inj       = ($urandom_range(0, 9) == 0);
      checks++; if ({ready_a, ready_b} !== {2{m_ready()}}) begin
        errors++; $display("FAIL rnd_ready@%0d got %b%b want %b", i, ready_a, ready_b, m_ready()); end
      checks++; if ({valid_a, valid_b} !== {2{q.size() > 0}}) begin
        errors++; $display("FAIL rnd_valid@%0d got %b%b want %b", i, valid_a, valid_b, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (data_a !== enc(q[0], 0, 0)) begin errors++; $display("FAIL rnd_data_a@%0d got %h want %h", i, data_a, enc(q[0], 0, 0)); end
        checks++; if (data_b !== enc(q[0], 1, 1)) begin errors++; $display("FAIL rnd_data_b@%0d got %h want %h", i, data_b, enc(q[0], 1, 1)); end
      end
      checks++; if ({pend_a, pend_b} !== {2{m_pending}}) begin
        errors++; $display("FAIL rnd_pending@%0d got %b%b want %b", i, pend_a, pend_b, m_pending); end
      checks++; if ({cnt_a, cnt_b} !== {2{m_cnt}}) begin
        errors++; $display("FAIL rnd_cnt@%0d got %h/%h want %h", i, cnt_a, cnt_b, m_cnt); end
      step();
    end
    src_valid = 0; inj = 0; grant = 1; step(); step();
  endtask

  task automatic test_wrap();
    int delivered = 0;
    int bubbles = 0;
    rst = 1; src_valid = 0; inj = 0; grant = 0;
    @(negedge clk); rst = 0; model_reset();
    step();
    grant = 1; src_valid = 1;
    for (int i = 0; i < 70000 && delivered < 65537; i++) begin
      if (i > 0 && valid_a !== 1'b1) bubbles++;
      src_data = $urandom;
      step();
      if (last_gnt) delivered++;
    end
    src_valid = 0;
    checks++; if (delivered !== 65537) begin errors++; $display("FAIL wrap_timeout got %0d want 65537", delivered); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL wrap_bubbles got %0d want 0", bubbles); end
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL wrap_cnt got %h want 0001", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_parity_encoding();
    test_backpressure();
    test_injection();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
